// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter / fetch sequencer in front of the instruction decoder.
// Prog_Addr addresses an async-read instruction ROM; the decoder answers in the
// same cycle with its flags, and the next PC is registered on the following
// edge, so one instruction is issued per clock with no bubbles.
// The block also owns the branch-target LUT (written byte-wise by the decoder),
// the IDLE/RUN/HALT/FAULT sequencing and a saturating count of RUN cycles.
//
// Ports
//   Clk, Reset                 clock (rising edge), async active-high reset
//   Start, Start_Addr          begin execution at Start_Addr (not in RUN)
//   PC_Jmp_Flag, PC_Beq_Flag   decoder: jump / branch taken
//   LUT_Write_En, LUT_Load_Hi  decoder: write LUT low byte (0) or high part (1)
//   LUT_Read_En, Lut_Idx       decoder: jump/branch target comes from LUT[Lut_Idx]
//   Lut_Data                   LUT write data
//   Ack                        decoder: halt
//   Prog_Addr                  current PC (registered)
//   Running, Done, Fault       state == RUN / HALT / FAULT
//   Cycle_Count                edges spent in RUN, saturating
//   Dbg_State                  raw state register for checkers
//
// Handshake: there is no valid/ready pair. The decoder's flags are qualified
// only by the RUN state and are consumed on every edge while running.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int  PC_W      = 10,
    parameter int  LUT_DEPTH = 16,
    parameter int  CNT_W     = 16,
    localparam int IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  Start_Addr,
    input  logic             PC_Jmp_Flag,
    input  logic             PC_Beq_Flag,
    input  logic             LUT_Write_En,
    input  logic             LUT_Read_En,
    input  logic             LUT_Load_Hi,
    input  logic [IDX_W-1:0] Lut_Idx,
    input  logic [7:0]       Lut_Data,
    input  logic             Ack,
    output logic [PC_W-1:0]  Prog_Addr,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic [1:0]       Dbg_State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [PC_W-1:0]  PC_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [CNT_W-1:0]    r_cnt;
    logic [PC_W-1:0]     r_lut [LUT_DEPTH];
    logic [LUT_DEPTH-1:0] r_valid;

    state_t              w_next_state;
    logic [PC_W-1:0]     w_next_pc;
    logic                w_idx_ok;
    logic                w_take;
    logic                w_lut_valid;
    logic [PC_W-1:0]     w_lut_entry;

    // Guards a non-power-of-two LUT: an index past the last entry reads as
    // invalid and its writes are dropped.
    assign w_idx_ok    = (32'(Lut_Idx) < LUT_DEPTH);
    // Jmp and Beq together behave as a single jump; a flag needs LUT_Read_En.
    assign w_take      = LUT_Read_En & (PC_Jmp_Flag | PC_Beq_Flag);
    // Reads see the register contents before this edge's write, so a
    // same-index write/read uses the old entry and old valid bit.
    assign w_lut_valid = w_idx_ok & r_valid[Lut_Idx];
    assign w_lut_entry = r_lut[Lut_Idx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            S_RUN: begin
                if (Ack) begin
                    w_next_state = S_HALT;
                end else if (w_take) begin
                    if (!w_lut_valid) begin
                        w_next_state = S_FAULT;
                    end else begin
                        w_next_pc = w_lut_entry;
                    end
                end else if (r_pc == PC_MAX) begin
                    // Running off the end of program space is a fault, never a wrap.
                    w_next_state = S_FAULT;
                end else begin
                    w_next_pc = r_pc + 1'b1;
                end
            end
            default: begin
                if (Start) begin
                    w_next_state = S_RUN;
                    w_next_pc    = Start_Addr;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (Start) begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
            r_valid <= '0;
        end else if ((r_state == S_RUN) && LUT_Write_En && w_idx_ok) begin
            if (LUT_Load_Hi) begin
                r_lut[Lut_Idx][PC_W-1:8] <= Lut_Data[PC_W-9:0];
            end else begin
                r_lut[Lut_Idx][7:0] <= Lut_Data;
            end
            r_valid[Lut_Idx] <= 1'b1;
        end
    end

    assign Prog_Addr   = r_pc;
    assign Running     = (r_state == S_RUN);
    assign Done        = (r_state == S_HALT);
    assign Fault       = (r_state == S_FAULT);
    assign Cycle_Count = r_cnt;
    assign Dbg_State   = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int CNT_W     = 16;
    localparam int VW        = PC_W + 3 + CNT_W;
    localparam int PC_LAST   = (1 << PC_W) - 1;
    localparam int CNT_LAST  = (1 << CNT_W) - 1;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [PC_W-1:0]  Start_Addr;
    logic             PC_Jmp_Flag;
    logic             PC_Beq_Flag;
    logic             LUT_Write_En;
    logic             LUT_Read_En;
    logic             LUT_Load_Hi;
    logic [3:0]       Lut_Idx;
    logic [7:0]       Lut_Data;
    logic             Ack;
    logic [PC_W-1:0]  Prog_Addr;
    logic             Running;
    logic             Done;
    logic             Fault;
    logic [CNT_W-1:0] Cycle_Count;
    logic [1:0]       Dbg_State;

    logic [VW-1:0]    w_obs;
    assign w_obs = {Prog_Addr, Running, Done, Fault, Cycle_Count};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural view only (mode flags, PC, count, LUT).
    bit m_run, m_done, m_fault;
    int m_pc, m_cnt;
    int m_lut [LUT_DEPTH];
    bit m_valid [LUT_DEPTH];
    logic [VW-1:0] exp_q [$];

    pc_fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Start_Addr(Start_Addr),
        .PC_Jmp_Flag(PC_Jmp_Flag), .PC_Beq_Flag(PC_Beq_Flag),
        .LUT_Write_En(LUT_Write_En), .LUT_Read_En(LUT_Read_En),
        .LUT_Load_Hi(LUT_Load_Hi), .Lut_Idx(Lut_Idx), .Lut_Data(Lut_Data),
        .Ack(Ack), .Prog_Addr(Prog_Addr), .Running(Running), .Done(Done),
        .Fault(Fault), .Cycle_Count(Cycle_Count), .Dbg_State(Dbg_State)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            m_lut[i] = 0;
            m_valid[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        int  idx;
        int  old_entry;
        bit  old_v;
        bit  take;
        idx       = int'(Lut_Idx);
        old_entry = m_lut[idx];
        old_v     = m_valid[idx];
        if (m_run) begin
            if (m_cnt < CNT_LAST) m_cnt = m_cnt + 1;
            take = LUT_Read_En && (PC_Jmp_Flag || PC_Beq_Flag);
            if (Ack) begin
                m_run = 0; m_done = 1;
            end else if (take) begin
                if (!old_v) begin
                    m_run = 0; m_fault = 1;
                end else begin
                    m_pc = old_entry;
                end
            end else if (m_pc == PC_LAST) begin
                m_run = 0; m_fault = 1;
            end else begin
                m_pc = m_pc + 1;
            end
            if (LUT_Write_En) begin
                if (LUT_Load_Hi)
                    m_lut[idx] = (m_lut[idx] % 256) + (int'(Lut_Data) % (1 << (PC_W - 8))) * 256;
                else
                    m_lut[idx] = (m_lut[idx] / 256) * 256 + int'(Lut_Data);
                m_valid[idx] = 1;
            end
        end else if (Start) begin
            m_run = 1; m_done = 0; m_fault = 0;
            m_pc = int'(Start_Addr);
            m_cnt = 0;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [PC_W-1:0]  pcv;
        logic [CNT_W-1:0] cv;
        pcv = m_pc[PC_W-1:0];
        cv  = m_cnt[CNT_W-1:0];
        return {pcv, m_run, m_done, m_fault, cv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_clear();
        Start = 0; PC_Jmp_Flag = 0; PC_Beq_Flag = 0; LUT_Write_En = 0;
        LUT_Read_En = 0; LUT_Load_Hi = 0; Lut_Idx = '0; Lut_Data = '0; Ack = 0;
    endtask

    // One active edge: model sees the same inputs the DUT sampled; the
    // expected state is queued and outputs are then settled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        model_edge();
        exp_q.push_back(exp_vec());
        #1;
    endtask

    task automatic start_at(input int addr);
        drive_clear();
        Start = 1; Start_Addr = addr[PC_W-1:0];
        tick();
        Start = 0;
    endtask

    task automatic lut_write(input int idx, input bit hi, input int data);
        drive_clear();
        LUT_Write_En = 1; LUT_Load_Hi = hi; Lut_Idx = idx[3:0]; Lut_Data = data[7:0];
        tick();
        drive_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [VW-1:0] zero_v;
        zero_v = '0;
        drive_clear();
        Start_Addr = '0;
        Reset = 1;
        #1;
        model_reset();
        n_checks++;
        if (w_obs !== zero_v) begin
            n_errors++;
            $display("FAIL reset_async: got %h want %h", w_obs, zero_v);
        end
        @(negedge Clk);
        #2;
        Reset = 0;
        tick();
        n_checks++;
        if (w_obs !== exp_q.pop_front() || w_obs !== zero_v) begin
            n_errors++;
            $display("FAIL reset_idle_hold: got %h want %h", w_obs, zero_v);
        end
    endtask

    task automatic test_sequential();
        logic [VW-1:0] e;
        start_at(5);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            e = exp_q.pop_front();
            n_checks++;
            if (w_obs !== e || Prog_Addr !== PC_W'(5 + k) || Cycle_Count !== CNT_W'(k) || Running !== 1'b1) begin
                n_errors++;
                $display("FAIL seq_step%0d: got pc=%h cnt=%0d run=%b want pc=%h cnt=%0d", k, Prog_Addr, Cycle_Count, Running, 5 + k, k);
            end
        end
    endtask

    task automatic test_lut_jump();
        logic [VW-1:0] e;
        lut_write(3, 0, 8'h20);
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e) begin n_errors++; $display("FAIL lut_wr_lo: got %h want %h", w_obs, e); end
        lut_write(3, 1, 8'h01);
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e) begin n_errors++; $display("FAIL lut_wr_hi: got %h want %h", w_obs, e); end
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd3;
        tick();
        drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h120 || Running !== 1'b1) begin
            n_errors++; $display("FAIL lut_jump: got pc=%h want pc=120 (model %h vs %h)", Prog_Addr, w_obs, e);
        end
    endtask

    task automatic test_beq();
        logic [VW-1:0] e;
        for (int beq = 0; beq < 2; beq++) begin
            Ack = 1; tick(); void'(exp_q.pop_front());
            n_checks++;
            if (Done !== 1'b1) begin n_errors++; $display("FAIL beq_halt%0d: got done=%b want 1", beq, Done); end
            start_at(10'h10); void'(exp_q.pop_front());
            LUT_Read_En = 1; PC_Beq_Flag = beq[0]; Lut_Idx = 4'd3;
            tick();
            drive_clear();
            e = exp_q.pop_front(); n_checks++;
            if (w_obs !== e || Prog_Addr !== (beq != 0 ? 10'h120 : 10'h11)) begin
                n_errors++; $display("FAIL beq_%0d: got pc=%h want pc=%h", beq, Prog_Addr, beq != 0 ? 10'h120 : 10'h11);
            end
        end
    endtask

    task automatic test_fault();
        logic [VW-1:0] e;
        logic [PC_W-1:0] pc_before;
        pc_before = Prog_Addr;
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd7;
        tick();
        drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Fault !== 1'b1 || Running !== 1'b0 || Prog_Addr !== pc_before) begin
            n_errors++; $display("FAIL fault_invalid: got %h want %h", w_obs, e);
        end
        start_at(0);
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Fault !== 1'b0 || Running !== 1'b1 || Prog_Addr !== 10'h000) begin
            n_errors++; $display("FAIL fault_restart: got %h want %h", w_obs, e);
        end
        // Same-edge write and read of a never-written index: read sees old valid.
        LUT_Write_En = 1; Lut_Data = 8'h33; Lut_Idx = 4'd9; PC_Jmp_Flag = 1; LUT_Read_En = 1;
        tick();
        drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Fault !== 1'b1) begin
            n_errors++; $display("FAIL same_edge_rw: got %h want %h", w_obs, e);
        end
        start_at(0); void'(exp_q.pop_front());
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd9;
        tick();
        drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h033) begin
            n_errors++; $display("FAIL same_edge_wr_landed: got pc=%h want 033", Prog_Addr);
        end
    endtask

    task automatic test_halt();
        logic [VW-1:0] e;
        logic [CNT_W-1:0] cnt_frozen;
        Ack = 1; tick(); void'(exp_q.pop_front()); drive_clear();
        start_at(8'h08); void'(exp_q.pop_front());
        tick(); tick(); void'(exp_q.pop_front()); void'(exp_q.pop_front());
        Ack = 1; tick(); drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Done !== 1'b1 || Prog_Addr !== 10'h00A || Running !== 1'b0) begin
            n_errors++; $display("FAIL halt_enter: got %h want %h", w_obs, e);
        end
        cnt_frozen = Cycle_Count;
        for (int k = 0; k < 2; k++) begin
            LUT_Write_En = 1; LUT_Load_Hi = 0; Lut_Data = 8'hFF; Lut_Idx = 4'd3;
            PC_Jmp_Flag = 1; LUT_Read_En = 1; Ack = 1;
            tick();
            e = exp_q.pop_front(); n_checks++;
            if (w_obs !== e || Prog_Addr !== 10'h00A || Cycle_Count !== cnt_frozen || Done !== 1'b1) begin
                n_errors++; $display("FAIL halt_ignore%0d: got %h want %h", k, w_obs, e);
            end
        end
        start_at(10'h40);
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h040 || Cycle_Count !== 16'd0 || Done !== 1'b0) begin
            n_errors++; $display("FAIL halt_restart: got %h want %h", w_obs, e);
        end
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd3;
        tick(); drive_clear();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h120) begin
            n_errors++; $display("FAIL halt_lut_kept: got pc=%h want 120", Prog_Addr);
        end
    endtask

    task automatic test_pc_end();
        logic [VW-1:0] e;
        Ack = 1; tick(); void'(exp_q.pop_front()); drive_clear();
        start_at(10'h3FE); void'(exp_q.pop_front());
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h3FF || Running !== 1'b1) begin
            n_errors++; $display("FAIL pc_last: got %h want %h", w_obs, e);
        end
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Prog_Addr !== 10'h3FF || Fault !== 1'b1) begin
            n_errors++; $display("FAIL pc_no_wrap: got %h want %h", w_obs, e);
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] e;
        start_at(0);
        lut_write(1, 0, 0);
        lut_write(1, 1, 0);
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd1;
        for (int k = 0; k < CNT_LAST + 4; k++) tick();
        drive_clear();
        exp_q.delete();
        tick();
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Cycle_Count !== 16'hFFFF || Running !== 1'b1) begin
            n_errors++; $display("FAIL cnt_saturate: got cnt=%h want FFFF (%h vs %h)", Cycle_Count, w_obs, e);
        end
    endtask

    task automatic test_reset_midrun();
        logic [VW-1:0] e;
        logic [VW-1:0] zero_v;
        zero_v = '0;
        Ack = 1; tick(); drive_clear();
        start_at(10'h20);
        tick(); tick();
        exp_q.delete();
        LUT_Write_En = 1; Lut_Idx = 4'd4; Lut_Data = 8'h55;
        #2;
        Reset = 1;
        #1;
        model_reset();
        n_checks++;
        if (w_obs !== zero_v) begin
            n_errors++; $display("FAIL reset_midrun: got %h want %h", w_obs, zero_v);
        end
        drive_clear();
        #1;
        Reset = 0;
        start_at(0);
        PC_Jmp_Flag = 1; LUT_Read_En = 1; Lut_Idx = 4'd3;
        tick(); drive_clear();
        void'(exp_q.pop_front());
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Fault !== 1'b1) begin
            n_errors++; $display("FAIL reset_lut_cleared: got %h want %h", w_obs, e);
        end
        start_at(0);
        LUT_Read_En = 1; PC_Beq_Flag = 1; Lut_Idx = 4'd4;
        tick(); drive_clear();
        void'(exp_q.pop_front());
        e = exp_q.pop_front(); n_checks++;
        if (w_obs !== e || Fault !== 1'b1) begin
            n_errors++; $display("FAIL reset_inflight_lost: got %h want %h", w_obs, e);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        for (int k = 0; k < 600; k++) begin
            Start        = ($urandom_range(0, 3) == 0);
            Start_Addr   = ($urandom_range(0, 7) == 0) ? PC_W'(10'h3F8 + $urandom_range(0, 7)) : PC_W'($urandom_range(0, PC_LAST));
            PC_Jmp_Flag  = ($urandom_range(0, 4) == 0);
            PC_Beq_Flag  = ($urandom_range(0, 4) == 0);
            LUT_Read_En  = ($urandom_range(0, 2) == 0);
            LUT_Write_En = ($urandom_range(0, 2) == 0);
            LUT_Load_Hi  = $urandom_range(0, 1) != 0;
            Lut_Idx      = 4'($urandom_range(0, 5));
            Lut_Data     = 8'($urandom_range(0, 255));
            Ack          = ($urandom_range(0, 15) == 0);
            tick();
            e = exp_q.pop_front(); n_checks++;
            if (w_obs !== e) begin
                n_errors++; $display("FAIL random[%0d]: got %h want %h", k, w_obs, e);
            end
        end
        drive_clear();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_lut_jump();
        test_beq();
        test_fault();
        test_halt();
        test_pc_end();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
